// File: rtl/ram_model_sync.sv
// Behavioural word-RAM slave: in-order request queue, fixed access time, one-cycle read ack.
// Optional macro RAM_MODEL_PREFILL_EN preloads mem[i] = i ^ 'hA5A5 at time zero (simulation content).
module ram_model_sync #(
  parameter int ADDR_SIZE     = 13,
  parameter int WORD_SIZE     = 16,
  parameter int ACCESS_CYCLES = 4,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 not_reset,
  input  logic [ADDR_SIZE-1:0] ram_addr,
  input  logic [WORD_SIZE-1:0] ram_wdata,
  input  logic                 ram_avalid,
  input  logic                 ram_rnw,
  output logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 ram_ack,
  output logic                 busy,
  output logic                 overflow
);

  localparam int ENTRY_W   = 1 + ADDR_SIZE + WORD_SIZE;
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam int TMR_W     = $clog2(ACCESS_CYCLES + 1);
  localparam int MEM_WORDS = 1 << ADDR_SIZE;

  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QUEUE_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACCESS_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [WORD_SIZE-1:0] cur_wdata_q, cur_wdata_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [WORD_SIZE-1:0] rdata_q;

  logic                 q_empty, q_full;
  logic                 push, pop, mem_we, mem_re;
  logic [ENTRY_W-1:0]   push_entry, head_entry;
  logic                 head_rnw;
  logic [ADDR_SIZE-1:0] head_addr;
  logic [WORD_SIZE-1:0] head_wdata;

  logic [ENTRY_W-1:0]   slot_rd [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  // ---------------- request queue ----------------
  assign q_empty    = (count_q == '0);
  assign q_full     = (count_q == Q_FULL);
  assign push_entry = {ram_rnw, ram_addr, ram_wdata};
  // A full queue still accepts when the head leaves at the same edge.
  assign push       = ram_avalid && (!q_full || pop);

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
      logic [ENTRY_W-1:0] slot_q;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          slot_q <= push_entry;
        end
      end
      assign slot_rd[gi] = slot_q;
    end
  endgenerate

  assign head_entry = slot_rd[rd_ptr_q];
  assign head_rnw   = head_entry[ENTRY_W-1];
  assign head_addr  = head_entry[ADDR_SIZE+WORD_SIZE-1:WORD_SIZE];
  assign head_wdata = head_entry[WORD_SIZE-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ram_avalid && !push) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------- access sequencer ----------------
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    pop         = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pop = !q_empty;
      end
      ST_ACCESS: begin
        if (tmr_q == '0) begin
          mem_re  = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WRITE: begin
        if (tmr_q == '0) begin
          mem_we  = 1'b1;
          pop     = !q_empty;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        pop     = !q_empty;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Popping always starts the next request, whatever state it leaves.
    if (pop) begin
      cur_addr_d  = head_addr;
      cur_wdata_d = head_wdata;
      tmr_d       = TMR_LOAD;
      state_d     = head_rnw ? ST_ACCESS : ST_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!not_reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------- storage ----------------
`ifdef RAM_MODEL_PREFILL_EN
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[ADDR_SIZE'(i)] = WORD_SIZE'(i ^ 32'hA5A5);
    end
  end
`endif

  // A write landing on a reset edge belongs to a discarded request.
  always_ff @(posedge clk) begin
    if (mem_we && not_reset) begin
      mem[cur_addr_q] <= cur_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!not_reset) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem[cur_addr_q];
    end
  end

  assign ram_rdata = rdata_q;
  assign ram_ack   = (state_q == ST_ACK);
  assign busy      = !q_empty || (state_q != ST_IDLE);
  assign overflow  = overflow_q;

endmodule
